// File: rtl/sensor_conditioner.sv
// Conditions the raw vehicle-loop inputs of roads A and B into clean request levels:
// 2-FF synchroniser, debounce FSM, request latch held until served, saturating car counter.
module sensor_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_a,
  input  logic             raw_b,
  input  logic             ga,
  input  logic             gb,
  input  logic             clr_cnt,
  output logic             sa,
  output logic             sb,
  output logic             det_a,
  output logic             det_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  typedef enum logic [1:0] {IDLE, RISE, HIGH, FALL} db_state_t;

  logic [1:0]       raw;
  logic [1:0]       green;
  logic [1:0]       det_v;
  logic [1:0]       req_v;
  logic [CNT_W-1:0] cnt_v [2];

  assign raw   = {raw_b, raw_a};
  assign green = {gb, ga};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_road
      logic             s1;
      logic             s2;
      logic             det;
      logic             req;
      logic             rise;
      db_state_t        state;
      logic [DB_W-1:0]  db_cnt;
      logic [CNT_W-1:0] cnt;

      // One-cycle strobe on the RISE->HIGH transition; drives latch and counter.
      assign rise = (state == RISE) && s2 && (db_cnt == DB_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          s1     <= 1'b0;
          s2     <= 1'b0;
          det    <= 1'b0;
          req    <= 1'b0;
          state  <= IDLE;
          db_cnt <= '0;
          cnt    <= '0;
        end else begin
          s1 <= raw[gi];
          s2 <= s1;

          case (state)
            IDLE: begin
              if (s2) begin
                state  <= RISE;
                db_cnt <= DB_ONE;
              end
            end
            RISE: begin
              if (!s2) begin
                state  <= IDLE;
                db_cnt <= '0;
              end else if (db_cnt == DB_LAST) begin
                state  <= HIGH;
                det    <= 1'b1;
                db_cnt <= '0;
              end else begin
                db_cnt <= db_cnt + DB_ONE;
              end
            end
            HIGH: begin
              if (!s2) begin
                state  <= FALL;
                db_cnt <= DB_ONE;
              end
            end
            FALL: begin
              if (s2) begin
                state  <= HIGH;
                db_cnt <= '0;
              end else if (db_cnt == DB_LAST) begin
                state  <= IDLE;
                det    <= 1'b0;
                db_cnt <= '0;
              end else begin
                db_cnt <= db_cnt + DB_ONE;
              end
            end
            default: begin
              state  <= IDLE;
              db_cnt <= '0;
            end
          endcase

          // A new arrival beats a simultaneous "served and gone" clear.
          if (rise) begin
            req <= 1'b1;
          end else if (green[gi] && !det) begin
            req <= 1'b0;
          end

          if (clr_cnt) begin
            cnt <= '0;
          end else if (rise && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign det_v[gi] = det;
      assign req_v[gi] = req;
      assign cnt_v[gi] = cnt;
    end
  endgenerate

  assign sa    = req_v[0];
  assign sb    = req_v[1];
  assign det_a = det_v[0];
  assign det_b = det_v[1];
  assign cnt_a = cnt_v[0];
  assign cnt_b = cnt_v[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a sample-history reference model.
module tb_sensor_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw_a = 1'b0, raw_b = 1'b0, ga = 1'b0, gb = 1'b0, clr_cnt = 1'b0;
  logic       sa, sb, det_a, det_b;
  logic [7:0] cnt_a, cnt_b;
  logic       sa2, sb2, det_a2, det_b2;
  logic [1:0] cnt2_a, cnt2_b;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  sensor_conditioner #(.DEBOUNCE(DEB), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .raw_a(raw_a), .raw_b(raw_b), .ga(ga), .gb(gb),
    .clr_cnt(clr_cnt), .sa(sa), .sb(sb), .det_a(det_a), .det_b(det_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  sensor_conditioner #(.DEBOUNCE(DEB), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .raw_a(raw_a), .raw_b(raw_b), .ga(ga), .gb(gb),
    .clr_cnt(clr_cnt), .sa(sa2), .sb(sb2), .det_a(det_a2), .det_b(det_b2),
    .cnt_a(cnt2_a), .cnt_b(cnt2_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw passes a 2-sample delay; det flips once the last DEB delayed
  // samples all disagree with it; requests and counters follow from the flips.
  bit m_pipe [2][2];
  bit m_hist [2][DEB];
  bit m_det  [2];
  bit m_req  [2];
  int m_cnt8 [2];
  int m_cnt2 [2];

  always @(posedge clk) begin
    bit raw_now [2];
    bit grn [2];
    bit samp, all_flip, rise;
    raw_now[0] = raw_a; raw_now[1] = raw_b;
    grn[0] = ga;        grn[1] = gb;
    for (int r = 0; r < 2; r++) begin
      if (rst) begin
        m_pipe[r][0] = 0; m_pipe[r][1] = 0;
        for (int k = 0; k < DEB; k++) m_hist[r][k] = 0;
        m_det[r] = 0; m_req[r] = 0; m_cnt8[r] = 0; m_cnt2[r] = 0;
      end else begin
        samp = m_pipe[r][1];
        m_pipe[r][1] = m_pipe[r][0];
        m_pipe[r][0] = raw_now[r];
        for (int k = DEB - 1; k > 0; k--) m_hist[r][k] = m_hist[r][k-1];
        m_hist[r][0] = samp;
        all_flip = 1;
        for (int k = 0; k < DEB; k++) if (m_hist[r][k] == m_det[r]) all_flip = 0;
        rise = all_flip && !m_det[r];
        if (rise) m_req[r] = 1;
        else if (grn[r] && !m_det[r]) m_req[r] = 0;
        if (clr_cnt) begin
          m_cnt8[r] = 0; m_cnt2[r] = 0;
        end else if (rise) begin
          if (m_cnt8[r] < 255) m_cnt8[r]++;
          if (m_cnt2[r] < 3) m_cnt2[r]++;
        end
        if (all_flip) m_det[r] = !m_det[r];
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model sa",     sa,     m_req[0]);
      chk("model sb",     sb,     m_req[1]);
      chk("model det_a",  det_a,  m_det[0]);
      chk("model det_b",  det_b,  m_det[1]);
      chk("model cnt_a",  cnt_a,  m_cnt8[0]);
      chk("model cnt_b",  cnt_b,  m_cnt8[1]);
      chk("model cnt2_a", cnt2_a, m_cnt2[0]);
      chk("model cnt2_b", cnt2_b, m_cnt2[1]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int run_a = 0;
    int run_b = 0;

    tick(3);
    check_en = 1'b1;
    chk("reset sa", sa, 0);
    chk("reset det_a", det_a, 0);
    chk("reset cnt_a", cnt_a, 0);
    rst = 1'b0;

    // Glitch: three captured highs never reach det.
    raw_a = 1'b1; tick(3); raw_a = 1'b0; tick(10);
    chk("glitch det_a", det_a, 0);
    chk("glitch sa", sa, 0);
    chk("glitch cnt_a", cnt_a, 0);
    $display("phase glitch: det_a=%0d sa=%0d cnt_a=%0d", det_a, sa, cnt_a);

    // Clean arrival: captured at edge 0, det after edge 5.
    raw_a = 1'b1; tick(5);
    chk("arrive det_a early", det_a, 0);
    tick(1);
    chk("arrive det_a", det_a, 1);
    chk("arrive sa", sa, 1);
    chk("arrive cnt_a", cnt_a, 1);
    chk("arrive sb", sb, 0);
    chk("arrive det_b", det_b, 0);
    $display("phase arrival: det_a=%0d sa=%0d cnt_a=%0d", det_a, sa, cnt_a);

    // Service with ga low during departure.
    raw_a = 1'b0; tick(5);
    chk("depart det_a early", det_a, 1);
    tick(1);
    chk("depart det_a", det_a, 0);
    tick(3);
    chk("depart sa held", sa, 1);
    ga = 1'b1; tick(1);
    chk("served sa", sa, 0);
    ga = 1'b0;

    // Second arrival, then depart with ga already high.
    raw_a = 1'b1; tick(6);
    chk("arrive2 cnt_a", cnt_a, 2);
    ga = 1'b1; raw_a = 1'b0; tick(6);
    chk("green depart det_a", det_a, 0);
    chk("green depart sa", sa, 1);
    tick(1);
    chk("green depart sa clr", sa, 0);
    ga = 1'b0;
    $display("phase service: sa=%0d det_a=%0d", sa, det_a);

    // Bounce while falling.
    raw_a = 1'b1; tick(6);
    chk("bounce pre cnt_a", cnt_a, 3);
    raw_a = 1'b0; tick(2); raw_a = 1'b1; tick(10);
    chk("bounce det_a", det_a, 1);
    chk("bounce cnt_a", cnt_a, 3);

    // Clear coincident with det_rise.
    raw_a = 1'b0; tick(10);
    raw_a = 1'b1; tick(5);
    clr_cnt = 1'b1; tick(1); clr_cnt = 1'b0;
    chk("clr rise cnt_a", cnt_a, 0);
    chk("clr rise sa", sa, 1);
    chk("clr rise det_a", det_a, 1);

    // Five arrivals saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      raw_a = 1'b0; tick(7);
      raw_a = 1'b1; tick(7);
    end
    chk("sat cnt2_a", cnt2_a, 3);
    chk("sat cnt_a", cnt_a, 5);
    $display("phase saturate: cnt_a=%0d cnt2_a=%0d", cnt_a, cnt2_a);

    // Reset in the middle of a rising debounce while sb is latched.
    raw_b = 1'b1; tick(6);
    chk("pre rst sb", sb, 1);
    raw_a = 1'b0; tick(7);
    raw_a = 1'b1; tick(4);
    rst = 1'b1; tick(1);
    chk("rst sa", sa, 0);
    chk("rst sb", sb, 0);
    chk("rst det_b", det_b, 0);
    chk("rst cnt_a", cnt_a, 0);
    rst = 1'b0; tick(5);
    chk("post rst det_a early", det_a, 0);
    tick(1);
    chk("post rst det_a", det_a, 1);
    chk("post rst det_b", det_b, 1);
    $display("phase reset: det_a=%0d det_b=%0d sa=%0d sb=%0d", det_a, det_b, sa, sb);

    // Randomised traffic against the model.
    repeat (4000) begin
      if (run_a == 0) begin raw_a = 1'($urandom_range(0, 1)); run_a = $urandom_range(1, 9); end
      if (run_b == 0) begin raw_b = 1'($urandom_range(0, 1)); run_b = $urandom_range(1, 9); end
      run_a--; run_b--;
      if ($urandom_range(0, 15) == 0) ga = ~ga;
      if ($urandom_range(0, 15) == 0) gb = ~gb;
      clr_cnt = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0; clr_cnt = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
